regfile_dump: RTL

Sequential read-out engine for the processor's 32×32 register file. On a `start` pulse it walks register indices 0..NUM_REGISTERS-1 through one register-file read port and streams each word out on a valid/ready interface. It feeds the debug/trace path and sits beside the decode stage, sharing read port 1 when the core is halted.

---
 rtl/regfile_dump_pkg.sv | 16 +
 rtl/regfile_dump.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/regfile_dump_pkg.sv
// Shared register-file geometry and the dump engine state encoding.
package regfile_dump_pkg;

  localparam int RF_DATA_WIDTH    = 32;
  localparam int RF_NUM_REGISTERS = 32;
  localparam int RF_ADDR_WIDTH    = 5;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    CSUM,
    DONE
  } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Register-file dump engine: walks indices 0..NUM_REGISTERS-1 over one read port, one word per 2 cycles, held under out_ready backpressure.
// REGFILE_DUMP_CHECKSUM_EN appends an XOR checksum word at index NUM_REGISTERS.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int DATA_WIDTH    = RF_DATA_WIDTH,
  parameter int NUM_REGISTERS = RF_NUM_REGISTERS,
  parameter int ADDR_WIDTH    = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGISTERS - 1);

  dump_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH:0]   out_index_q, out_index_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  xfer;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam logic [ADDR_WIDTH:0] CSUM_IDX = (ADDR_WIDTH + 1)'(NUM_REGISTERS);
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
`endif

  assign xfer = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    acc_d       = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = FETCH;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      FETCH: begin
        state_d     = SEND;
        out_data_d  = rd_data;
        out_index_d = {1'b0, idx_q};
`ifdef REGFILE_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
        acc_d       = acc_q ^ rd_data;
`else
        out_last_d  = (idx_q == LAST_IDX);
`endif
      end
      SEND: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            idx_d       = '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            // acc_q already folds in the last register, captured during its FETCH
            state_d     = CSUM;
            out_data_d  = acc_q;
            out_index_d = CSUM_IDX;
            out_last_d  = 1'b1;
`else
            state_d     = DONE;
`endif
          end else begin
            idx_d   = idx_q + ADDR_WIDTH'(1);
            state_d = FETCH;
          end
        end
      end
      CSUM: begin
        if (xfer) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over a same-cycle transfer: that word is treated as undelivered.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      idx_d   = '0;
    end
    out_valid_d = (state_d == SEND) || (state_d == CSUM);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign rd_addr   = idx_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
